// File: rtl/iir_coeff_if.sv
// iir_coeff_if: control/coefficient bundle for the biquad coefficient controller.
//   master : control side -- drives writes, commit and the sample tick,
//            observes the active coefficients and status pulses.
//   slave  : iir_coeff_ctrl -- the mirror image.
// Signals:
//   wr_en/wr_addr/wr_data : shadow write (addr 0..4 = b0,b1,b2,a1,a2)
//   commit                : check the shadow set and apply it
//   sample_tick           : audio sample boundary pulse
//   b0,b1,b2,a1,a2        : active coefficients (signed Q2.14)
//   busy, wr_rej, commit_err, swap_done : status
interface iir_coeff_if #(
  parameter int COEF_W = 16
);
  logic                     wr_en;
  logic [2:0]               wr_addr;
  logic signed [COEF_W-1:0] wr_data;
  logic                     commit;
  logic                     sample_tick;
  logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;
  logic                     busy;
  logic                     wr_rej;
  logic                     commit_err;
  logic                     swap_done;

  modport master (
    output wr_en, wr_addr, wr_data, commit, sample_tick,
    input  b0, b1, b2, a1, a2, busy, wr_rej, commit_err, swap_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, sample_tick,
    output b0, b1, b2, a1, a2, busy, wr_rej, commit_err, swap_done
  );
endinterface

// File: rtl/iir_coeff_ctrl.sv
// iir_coeff_ctrl: shadow/active coefficient banks for a biquad IIR.
// Writes land in the shadow bank while idle; a commit runs a one-cycle
// stability (triangle) check on the shadow a1/a2 and, if it passes, waits
// for the next sample_tick to copy all five shadow values to the active
// bank on a single edge, so the filter never sees a mixed set.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset (both banks -> unity passthrough)
//   bus   : iir_coeff_if.slave (writes, commit, tick in; coefs/status out)

// One coefficient: shadow register plus its active copy.
module iir_coeff_slot #(
  parameter int                       COEF_W  = 16,
  parameter logic signed [COEF_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              swap,
  input  logic [COEF_W-1:0] din,
  output logic [COEF_W-1:0] shadow,
  output logic [COEF_W-1:0] active
);
  // ld (IDLE only) and swap (PENDING only) are mutually exclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= RST_VAL;
      active <= RST_VAL;
    end else begin
      if (ld)   shadow <= din;
      if (swap) active <= shadow;
    end
  end
endmodule

module iir_coeff_ctrl #(
  parameter int COEF_W = 16,
  parameter int ONE_Q  = 16384
) (
  input  logic         clk,
  input  logic         reset,
  iir_coeff_if.slave   bus
);
  localparam int NUM_COEF = 5;
  localparam int EXT_W    = COEF_W + 2;
  localparam logic signed [EXT_W-1:0] ONE_X = EXT_W'(ONE_Q);

  typedef enum logic [1:0] {IDLE, CHECK, PENDING} state_t;

  state_t state, state_nxt;
  logic   wr_ok, swap, chk_pass, commit_err_nxt;

  logic [NUM_COEF-1:0][COEF_W-1:0] shadow, active;

  assign wr_ok = bus.wr_en && (state == IDLE) && (bus.wr_addr <= 3'd4);

  genvar i;
  generate
    for (i = 0; i < NUM_COEF; i++) begin : g_slot
      iir_coeff_slot #(
        .COEF_W  (COEF_W),
        .RST_VAL ((i == 0) ? COEF_W'(ONE_Q) : COEF_W'(0))
      ) u_slot (
        .clk    (clk),
        .reset  (reset),
        .ld     (wr_ok && (bus.wr_addr == 3'(i))),
        .swap   (swap),
        .din    (bus.wr_data),
        .shadow (shadow[i]),
        .active (active[i])
      );
    end
  endgenerate

  // Triangle test on the shadow a1/a2. Two guard bits let |-2^(W-1)| and
  // ONE_Q + a2 be represented exactly.
  logic signed [EXT_W-1:0] a1_x, a2_x, a1_abs, a2_abs, a1_bound;

  always_comb begin
    a1_x     = {{2{shadow[3][COEF_W-1]}}, shadow[3]};
    a2_x     = {{2{shadow[4][COEF_W-1]}}, shadow[4]};
    a1_abs   = a1_x[EXT_W-1] ? -a1_x : a1_x;
    a2_abs   = a2_x[EXT_W-1] ? -a2_x : a2_x;
    a1_bound = ONE_X + a2_x;
    chk_pass = (a2_abs < ONE_X) && (a1_abs < a1_bound);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    swap           = 1'b0;
    commit_err_nxt = 1'b0;
    case (state)
      IDLE:    if (bus.commit) state_nxt = CHECK;
      CHECK: begin
        if (chk_pass) state_nxt = PENDING;
        else begin
          state_nxt      = IDLE;
          commit_err_nxt = 1'b1;
        end
      end
      PENDING: begin
        if (bus.sample_tick) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status pulses are registered: visible the cycle after their cause.
  logic wr_rej_q, commit_err_q, swap_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_rej_q     <= 1'b0;
      commit_err_q <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      wr_rej_q     <= bus.wr_en && !wr_ok;
      commit_err_q <= commit_err_nxt;
      swap_done_q  <= swap;
    end
  end

  assign bus.b0         = active[0];
  assign bus.b1         = active[1];
  assign bus.b2         = active[2];
  assign bus.a1         = active[3];
  assign bus.a2         = active[4];
  assign bus.busy       = (state != IDLE);
  assign bus.wr_rej     = wr_rej_q;
  assign bus.commit_err = commit_err_q;
  assign bus.swap_done  = swap_done_q;
endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed bench for iir_coeff_ctrl. Inputs change 1 ns after the rising
// edge; outputs are checked at the same point, away from the edge.
module tb_iir_coeff_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nmiss = 0;

  always #5 clk = ~clk;

  iir_coeff_if #(.COEF_W(16)) bus ();

  iir_coeff_ctrl #(.COEF_W(16), .ONE_Q(16384)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_coef(input string tag, input int e0, input int e1,
                          input int e2, input int e3, input int e4);
    chk({tag, ".b0"}, int'(bus.b0), e0);
    chk({tag, ".b1"}, int'(bus.b1), e1);
    chk({tag, ".b2"}, int'(bus.b2), e2);
    chk({tag, ".a1"}, int'(bus.a1), e3);
    chk({tag, ".a2"}, int'(bus.a2), e4);
  endtask

  task automatic chk_stat(input string tag, input int busy, input int rej,
                          input int err, input int done);
    chk({tag, ".busy"},       int'(bus.busy),       busy);
    chk({tag, ".wr_rej"},     int'(bus.wr_rej),     rej);
    chk({tag, ".commit_err"}, int'(bus.commit_err), err);
    chk({tag, ".swap_done"},  int'(bus.swap_done),  done);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = 16'(data);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic cm();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.commit = 1'b0; bus.sample_tick = 1'b0;

    // Reset and idle
    repeat (3) step();
    chk_coef("rst_hold", 16384, 0, 0, 0, 0);
    chk_stat("rst_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) step();
    chk_coef("idle", 16384, 0, 0, 0, 0);
    chk_stat("idle", 0, 0, 0, 0);

    // Valid example set
    wr(0, 15871); wr(1, -30917); wr(2, 15106); wr(3, -30906); wr(4, 14618);
    chk("wr_ok.rej", int'(bus.wr_rej), 0);
    cm();                                      // now in CHECK
    chk("chk.busy", int'(bus.busy), 1);
    chk_coef("chk", 16384, 0, 0, 0, 0);
    step();                                    // PENDING
    step(); step();
    chk_coef("pend", 16384, 0, 0, 0, 0);
    chk_stat("pend", 1, 0, 0, 0);
    tick();
    chk_coef("swap1", 15871, -30917, 15106, -30906, 14618);
    chk_stat("swap1", 0, 0, 0, 1);
    step();
    chk("swap1.once", int'(bus.swap_done), 0);

    // Unstable: |a2| not < 1.0
    wr(3, 0); wr(4, 16384);
    cm(); step();
    chk_stat("uns_a2", 0, 0, 1, 0);
    chk_coef("uns_a2", 15871, -30917, 15106, -30906, 14618);
    step();
    chk("uns_a2.once", int'(bus.commit_err), 0);

    // Unstable: |a1| == 1.0 + a2 (strict)
    wr(4, 0); wr(3, -16384);
    cm(); step();
    chk("uns_a1.err", int'(bus.commit_err), 1);
    step();

    // |-32768| = 32768 must not wrap: a1=-32768, a2=16383 fails
    wr(3, -32768); wr(4, 16383);
    cm(); step();
    chk("uns_min.err", int'(bus.commit_err), 1);
    step();

    // Just-stable boundary a1=-16383, a2=0; b values kept from earlier
    wr(3, -16383); wr(4, 0);
    cm(); step();
    chk_stat("edge_ok", 1, 0, 0, 0);
    tick();
    chk_coef("edge_ok", 15871, -30917, 15106, -16383, 0);

    // Rejected writes: invalid address in IDLE, addr 0 during PENDING
    wr(6, 1234);
    chk("rej_addr.rej", int'(bus.wr_rej), 1);
    step();
    chk("rej_addr.once", int'(bus.wr_rej), 0);
    wr(1, 100);
    cm(); step();                              // PENDING
    wr(0, 999);
    chk("rej_pend.rej", int'(bus.wr_rej), 1);
    tick();
    chk_coef("rej_pend", 15871, 100, 15106, -16383, 0);
    chk("rej_pend.done", int'(bus.swap_done), 1);

    // Write + commit in the same cycle: commit sees the new a2
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'sd20000;
    bus.commit = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.commit = 1'b0;
    chk("sim_wc.rej", int'(bus.wr_rej), 0);
    step();
    chk("sim_wc.err", int'(bus.commit_err), 1);
    chk_coef("sim_wc", 15871, 100, 15106, -16383, 0);
    wr(4, 0);

    // Tick during CHECK is ignored; next tick swaps
    wr(2, 7);
    cm();                                      // CHECK
    tick();                                    // ignored, now PENDING
    chk_stat("tick_chk", 1, 0, 0, 0);
    chk("tick_chk.b2", int'(bus.b2), 15106);
    step();
    tick();
    chk("tick_pend.done", int'(bus.swap_done), 1);
    chk("tick_pend.b2", int'(bus.b2), 7);

    // Reset while PENDING
    wr(0, 5000);
    cm(); step();
    chk("rst_pend.busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_coef("rst_pend", 16384, 0, 0, 0, 0);
    chk_stat("rst_pend", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    tick();
    chk_stat("post_rst", 0, 0, 0, 0);
    tick();
    chk("post_rst.done2", int'(bus.swap_done), 0);
    chk_coef("post_rst", 16384, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule

// File: doc/iir_coeff_ctrl.md
# iir_coeff_ctrl

Coefficient controller for the biquad IIR filter in the audio path. Accepts coefficient writes from the control interface into a shadow bank, checks a committed set for stability, and copies it to the active bank only on a sample boundary, so the filter never runs a sample with a mixed coefficient set. Its outputs drive the filter's b0, b1, b2, a1 and a2 inputs directly, in place of hard-wired constants.

## Interface
- COEF_W, 16: coefficient width, signed Q2.14
- ONE_Q, 16384: value of 1.0 in Q2.14; unity-passthrough b0
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  shadow write strobe, one cycle per write
- wr_addr  input  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 invalid
- wr_data  input  COEF_W  signed coefficient
- commit  input  1  request to check the shadow set and apply it
- sample_tick  input  1  one-cycle pulse at each audio sample boundary
- b0, b1, b2, a1, a2  output  COEF_W each  active coefficients, registered
- busy  output  1  high when state is not IDLE
- wr_rej  output  1  one-cycle pulse: write rejected
- commit_err  output  1  one-cycle pulse: shadow set failed the stability check
- swap_done  output  1  one-cycle pulse: active bank updated this cycle

## Operation
- Reset (reset=0), asynchronous:
  - Shadow and active banks load unity passthrough: b0=ONE_Q; b1, b2, a1, a2 = 0.
  - State = IDLE; all pulse outputs = 0.
- Writes:
  - Accepted only in IDLE with wr_addr ≤ 4. The addressed shadow register updates on that edge.
  - In CHECK or PENDING, or with wr_addr ≥ 5, the write is dropped and wr_rej pulses the next cycle.
- FSM states: IDLE, CHECK, PENDING.
  - IDLE, commit=1 → CHECK. If wr_en and commit arrive in the same cycle, the write is accepted first, and CHECK evaluates the post-write shadow set.
  - CHECK (one cycle) evaluates the stability test on the shadow bank:
    - Pass → PENDING.
    - Fail → IDLE, with commit_err pulsing on the next cycle. The shadow bank keeps its contents; the active bank is unchanged.
  - PENDING, sample_tick=1 → copy all five shadow values to the active bank on that edge. swap_done is high for the following cycle; state returns to IDLE.
  - sample_tick while in CHECK is ignored; the swap waits for the next tick seen in PENDING.
  - commit while in CHECK or PENDING is ignored (no error flag).
- Stability test (triangle condition), with operands sign-extended to COEF_W+2 bits:
  - |a2| < ONE_Q, and
  - |a1| < ONE_Q + a2.
  - Both comparisons are strict. |−32768| must compute to +32768 without overflow, which the 18-bit extension provides.
- b coefficients are not range-checked.
- Reset asserted mid-operation, including in PENDING, aborts immediately. The active bank returns to unity passthrough and any pending set is lost.

## Timing
- Write to shadow: 1 cycle. Shadow contents are not visible on the outputs until a swap.
- Best-case commit-to-swap latency: commit at cycle N, CHECK at N+1, PENDING from N+2. A tick at N+2 updates the outputs at N+3, with swap_done high during N+3.
- Worst case is bounded by one sample period after PENDING is entered.
- All five active outputs change on the same clock edge. No intermediate mixed set is ever driven.
- busy rises the cycle after commit is accepted and falls the cycle swap_done or commit_err is high.
- wr_rej and commit_err are registered and appear 1 cycle after the causing event.

## Test plan
- Reset then idle:
  - Outputs b0=16384, b1=b2=a1=a2=0; busy=0; no pulses.
  - Assert reset low mid-run → same values within the same cycle.
- Valid load, fixed example set: write b0=15871, b1=−30917, b2=15106, a1=−30906, a2=14618, then commit.
  - Outputs stay at unity until the next sample_tick.
  - Then all five update on one edge, swap_done pulses once, busy drops.
- Unstable set: a2=16384 with a1=0, then commit → commit_err pulse, active bank unchanged.
  - Repeat with a2=0, a1=−16384 → commit_err, because |a1| is not < 16384.
- Write rejection:
  - wr_addr=6 in IDLE → wr_rej, shadow unchanged.
  - Write to addr 0 while in PENDING → wr_rej; the later swap uses the pre-commit value.
- Simultaneous events:
  - wr_en (addr 4, a2=20000) and commit in the same cycle → write lands, then commit_err (uses the new a2).
  - sample_tick during CHECK → no swap; swap occurs on the next tick.
- Reset in PENDING:
  - After a valid commit, pull reset low before any tick → outputs revert to unity, busy=0.
  - After reset release, further ticks produce no swap_done.
